computie_bus_initiator: RTL and testbench



---
 rtl/computie_bus_pkg.sv | 34 +++
 rtl/computie_bus_phase_timer.sv | 28 ++
 rtl/computie_bus_initiator.sv | 163 ++++++++++++++++
 tb/tb_computie_bus_initiator.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/computie_bus_pkg.sv
// Shared definitions for the Computie bus initiator.
// Holds the FSM state encoding and the request/response field offsets.
// The snooper record format uses the same offsets. Each offset is a function of
// the bus width so that every user derives the same layout.
package computie_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_RESPOND = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  // Request record: {read_write, addr, wdata}
  function automatic int req_rw_bit(input int bw);   return 2 * bw; endfunction
  function automatic int req_addr_lsb(input int bw); return bw;     endfunction
  function automatic int req_data_lsb(input int bw); return 0 * bw; endfunction

  // Response record: {error, read_write, rdata}
  function automatic int rsp_err_bit(input int bw);  return bw + 1; endfunction
  function automatic int rsp_rw_bit(input int bw);   return bw;     endfunction

  // Width of one counter that must hold the longest phase or the timeout.
  function automatic int phase_ctr_width(input int a, input int d, input int r, input int t);
    int m;
    m = a;
    if (d > m) m = d;
    if (r > m) m = r;
    if (t > m) m = t;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/computie_bus_phase_timer.sv
// Loadable down-counter. It times each bus phase and, when it is reloaded,
// the wait-extension timeout.
// Ports: clk/rst_n (async active low), load + load_val (takes priority over en),
//        en (decrement), done (count == 1).
// The count stops at 1 and never wraps. A stuck enable therefore keeps done
// asserted rather than producing a long false phase.
module computie_bus_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 count <= '0;
    else if (load)              count <= load_val;
    else if (en && count > ONE) count <= count - ONE;
  end

  assign done = (count == ONE);
endmodule

// File: rtl/computie_bus_initiator.sv
// Computie bus master. It takes {rw, addr, wdata} requests from a valid/ready
// stream and runs them as multiplexed address/data cycles. It returns one
// {error, rw, rdata} completion for each request.
// Ports: comm_clock, comm_reset (async active low); request_* in stream;
//        response_* out stream; cb_* bus pins; send_receive = transceiver dir.
// All outputs are registered. Each output takes its value for a state on the
// edge that enters that state.
module computie_bus_initiator
  import computie_bus_pkg::*;
#(
  parameter int BITWIDTH       = 32,
  parameter int ADDR_CYCLES    = 10,
  parameter int DATA_CYCLES    = 10,
  parameter int RECOVER_CYCLES = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                  comm_clock,
  input  logic                  comm_reset,
  input  logic                  request_valid,
  output logic                  request_ready,
  input  logic [2*BITWIDTH:0]   request_in,
  output logic                  response_valid,
  input  logic                  response_ready,
  output logic [BITWIDTH+1:0]   response_out,
  output logic                  cb_addr_strobe,
  output logic                  cb_data_strobe,
  output logic                  cb_read_write,
  output logic [BITWIDTH-1:0]   cb_ad_out,
  output logic                  cb_ad_oe,
  input  logic [BITWIDTH-1:0]   cb_ad_in,
  input  logic                  cb_wait,
  output logic                  send_receive
);
  localparam int CW      = phase_ctr_width(ADDR_CYCLES, DATA_CYCLES, RECOVER_CYCLES, TIMEOUT);
  localparam int Q_RW    = req_rw_bit(BITWIDTH);
  localparam int Q_ADDR  = req_addr_lsb(BITWIDTH);
  localparam int Q_DATA  = req_data_lsb(BITWIDTH);
  localparam int R_ERR   = rsp_err_bit(BITWIDTH);
  localparam int R_RW    = rsp_rw_bit(BITWIDTH);

  state_t                state;
  logic                  rw_q;
  logic [BITWIDTH-1:0]   wdata_q;
  logic                  ext;          // DATA has passed its counted length
  logic                  t_load, t_en, t_done;
  logic [CW-1:0]         t_val;
  logic                  accept, leave_data, timeout_hit;
  logic [BITWIDTH-1:0]   rdata_next;

  computie_bus_phase_timer #(.W(CW)) u_timer (
    .clk      (comm_clock),
    .rst_n    (comm_reset),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .done     (t_done)
  );

  // request_ready is 1 only in IDLE, so a handshake implies IDLE.
  always_comb begin
    accept      = request_valid && request_ready;
    // Extension continues while wait is seen. It ends when wait drops or the
    // timeout budget is used up.
    leave_data  = ext ? (!cb_wait || t_done) : (t_done && !cb_wait);
    timeout_hit = ext && cb_wait && t_done;
    rdata_next  = (timeout_hit || !rw_q) ? '0 : cb_ad_in;
  end

  // Timer control. Every phase entry reloads the timer. The same counter is
  // reloaded with TIMEOUT when DATA starts to extend.
  always_comb begin
    t_load = 1'b0;
    t_en   = 1'b0;
    t_val  = '0;
    case (state)
      ST_IDLE:    if (accept) begin t_load = 1'b1; t_val = CW'(ADDR_CYCLES); end
      ST_ADDR:    if (t_done) begin t_load = 1'b1; t_val = CW'(DATA_CYCLES); end
                  else t_en = 1'b1;
      ST_DATA:    if (!ext && t_done && cb_wait) begin t_load = 1'b1; t_val = CW'(TIMEOUT); end
                  else t_en = 1'b1;
      ST_RESPOND: if (response_ready) begin t_load = 1'b1; t_val = CW'(RECOVER_CYCLES); end
      ST_RECOVER: t_en = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge comm_clock or negedge comm_reset) begin
    if (!comm_reset) begin
      state          <= ST_IDLE;
      request_ready  <= 1'b0;
      response_valid <= 1'b0;
      response_out   <= '0;
      cb_addr_strobe <= 1'b1;
      cb_data_strobe <= 1'b1;
      cb_read_write  <= 1'b0;
      cb_ad_out      <= '0;
      cb_ad_oe       <= 1'b0;
      send_receive   <= 1'b0;
      rw_q           <= 1'b0;
      wdata_q        <= '0;
      ext            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state          <= ST_ADDR;
            request_ready  <= 1'b0;
            rw_q           <= request_in[Q_RW];
            wdata_q        <= request_in[Q_DATA +: BITWIDTH];
            cb_addr_strobe <= 1'b0;
            cb_read_write  <= request_in[Q_RW];
            cb_ad_out      <= request_in[Q_ADDR +: BITWIDTH];
            cb_ad_oe       <= 1'b1;
            send_receive   <= 1'b1;
          end else begin
            request_ready  <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (t_done) begin
            state          <= ST_DATA;
            cb_data_strobe <= 1'b0;
            ext            <= 1'b0;
            if (rw_q) begin
              // Read: release the bus so the target can drive it.
              cb_ad_oe     <= 1'b0;
              send_receive <= 1'b0;
            end else begin
              cb_ad_out    <= wdata_q;
            end
          end
        end
        ST_DATA: begin
          if (!ext && t_done && cb_wait) ext <= 1'b1;
          if (leave_data) begin
            state          <= ST_RESPOND;
            cb_addr_strobe <= 1'b1;
            cb_data_strobe <= 1'b1;
            cb_ad_oe       <= 1'b0;
            send_receive   <= 1'b0;
            response_valid <= 1'b1;
            response_out[R_ERR]          <= timeout_hit;
            response_out[R_RW]           <= rw_q;
            response_out[BITWIDTH-1:0]   <= rdata_next;
          end
        end
        ST_RESPOND: begin
          if (response_ready) begin
            state          <= ST_RECOVER;
            response_valid <= 1'b0;
          end
        end
        ST_RECOVER: begin
          if (t_done) begin
            state         <= ST_IDLE;
            request_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_computie_bus_initiator.sv
// Self-checking bench for computie_bus_initiator.
// Each transaction is scored against expectations that come from the timing
// rules: phase lengths, the number of extension cycles and the timeout cap.
module tb_computie_bus_initiator;
  localparam int A  = 10;
  localparam int D  = 10;
  localparam int R  = 4;
  localparam int TO = 255;

  logic        gclk;
  logic        comm_reset;
  logic        request_valid, request_ready;
  logic [64:0] request_in;
  logic        response_valid, response_ready;
  logic [33:0] response_out;
  logic        cb_addr_strobe, cb_data_strobe, cb_read_write, cb_ad_oe, send_receive, cb_wait;
  logic [31:0] cb_ad_out, cb_ad_in;

  int n_chk = 0;
  int n_err = 0;
  int n, bad;

  computie_bus_initiator dut (
    .comm_clock     (gclk),
    .comm_reset     (comm_reset),
    .request_valid  (request_valid),
    .request_ready  (request_ready),
    .request_in     (request_in),
    .response_valid (response_valid),
    .response_ready (response_ready),
    .response_out   (response_out),
    .cb_addr_strobe (cb_addr_strobe),
    .cb_data_strobe (cb_data_strobe),
    .cb_read_write  (cb_read_write),
    .cb_ad_out      (cb_ad_out),
    .cb_ad_oe       (cb_ad_oe),
    .cb_ad_in       (cb_ad_in),
    .cb_wait        (cb_wait),
    .send_receive   (send_receive)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // w = number of consecutive cycles with cb_wait high, starting on the last
  // counted DATA cycle. hold = cycles response_ready is held low.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rbus, input int w, input int hold);
    int          ext, k, c, as_n, ds_n, errs, lat;
    logic        err;
    logic [33:0] exp_rsp, rsp0;
    ext     = (w < TO) ? w : TO;
    err     = (w > TO);
    exp_rsp = {err, rw, (err || !rw) ? 32'h0 : rbus};

    request_in     = {rw, addr, wdata};
    request_valid  = 1'b1;
    response_ready = 1'b0;
    cb_wait        = 1'b0;
    k = 0;
    while (!request_ready && k < 100) begin @(negedge gclk); k++; end
    chk("accept_wait", 64'(k < 100), 64'd1);
    @(posedge gclk); #1;
    // The latched request must not follow these later changes.
    request_valid = 1'b0;
    request_in    = {~rw, ~addr, ~wdata};

    as_n = 0; ds_n = 0; errs = 0; lat = -1;
    for (c = 1; c <= 600; c++) begin
      @(negedge gclk);
      if (response_valid) begin lat = c - 1; break; end
      if (!cb_addr_strobe) as_n++;
      if (!cb_data_strobe) ds_n++;
      if (request_ready) errs++;
      if (!cb_addr_strobe && cb_data_strobe &&
          !(cb_ad_out == addr && cb_ad_oe && send_receive && cb_read_write == rw)) errs++;
      if (!cb_data_strobe) begin
        if (rw ? (cb_ad_oe || send_receive)
               : !(cb_ad_out == wdata && cb_ad_oe && send_receive)) errs++;
      end
      cb_wait  = (c - A >= D) && (c - A <= D + w - 1);
      cb_ad_in = (c == A + D + ext) ? rbus : $urandom;
    end
    cb_wait = 1'b0;
    chk("latency",   64'(lat),  64'(A + D + ext));
    chk("as_low",    64'(as_n), 64'(A + D + ext));
    chk("ds_low",    64'(ds_n), 64'(D + ext));
    chk("phase_bus", 64'(errs), 64'd0);
    chk("response",  64'(response_out), 64'(exp_rsp));

    rsp0 = response_out; errs = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge gclk);
      if (response_out != rsp0 || !response_valid || request_ready ||
          !cb_addr_strobe || !cb_data_strobe || cb_ad_oe) errs++;
    end
    if (hold > 0) chk("hold_stable", 64'(errs), 64'd0);

    response_ready = 1'b1;
    @(negedge gclk);
    response_ready = 1'b0;
    chk("valid_drop", 64'(response_valid), 64'd0);
    k = 1;
    while (!request_ready && k < 50) begin @(negedge gclk); k++; end
    chk("recover", 64'(k), 64'(R + 1));
  endtask

  initial begin
    comm_reset = 1'b0; request_valid = 1'b0; request_in = '0;
    response_ready = 1'b0; cb_ad_in = '0; cb_wait = 1'b0;
    repeat (3) @(negedge gclk);
    chk("rst_strobes", {62'd0, cb_addr_strobe, cb_data_strobe}, 64'd3);
    chk("rst_bus",     {30'd0, cb_read_write, cb_ad_oe, send_receive, cb_ad_out}, 64'd0);
    chk("rst_stream",  {28'd0, request_ready, response_valid, response_out}, 64'd0);
    comm_reset = 1'b1;

    run_txn(1'b0, 32'h2020FFFF, 32'hAAAAAAAA, 32'h0,        0,    0);
    run_txn(1'b1, 32'h12345678, 32'hDEADBEEF, 32'h55555555, 0,    0);
    run_txn(1'b1, 32'h0000BEEF, 32'h0,        32'h0F0F1234, 5,    1);
    run_txn(1'b0, 32'h11110000, 32'h87654321, 32'h0,        5,    0);
    run_txn(1'b1, 32'h0BADF00D, 32'h0,        32'hFFFFFFFF, 1000, 0);
    run_txn(1'b1, 32'h00C0FFEE, 32'h0,        32'h13579BDF, TO,   0);
    run_txn(1'b0, 32'h00000001, 32'h5A5A5A5A, 32'h0,        0,    20);
    run_txn(1'b1, 32'hFFFFFFFF, 32'h0,        32'h2468ACE0, 1,    0);
    for (int t = 0; t < 8; t++)
      run_txn(1'($urandom), $urandom, $urandom, $urandom,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0,
              int'($urandom_range(0, 3)));

    // Assert reset partway through a write's DATA phase.
    request_in = {1'b0, 32'hCAFE0000, 32'h12345678}; request_valid = 1'b1;
    n = 0;
    while (!request_ready && n < 100) begin @(negedge gclk); n++; end
    @(posedge gclk); #1;
    request_valid = 1'b0;
    repeat (A + 3) @(negedge gclk);
    chk("pre_rst_ds", 64'(cb_data_strobe), 64'd0);
    #2 comm_reset = 1'b0;
    #1;
    chk("rst_mid_strobes", {62'd0, cb_addr_strobe, cb_data_strobe}, 64'd3);
    chk("rst_mid_oe",      {62'd0, cb_ad_oe, send_receive}, 64'd0);
    @(negedge gclk);
    comm_reset = 1'b1;
    bad = 0;
    repeat (40) @(negedge gclk) if (response_valid) bad++;
    chk("rst_no_resp", 64'(bad), 64'd0);
    run_txn(1'b0, 32'h3C3C3C3C, 32'h0F1E2D3C, 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
